// File: rtl/cayde_fetch.sv
// Instruction fetch stage: sequential PC generation, credit-limited memory requests,
// in-order instruction buffer and redirect flush. Optional macro: CAYDE_FETCH_MISALIGN_CHECK_EN.
module cayde_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        fetch_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_HALT = 1'b1;

  logic          state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [31:0]   rsp_pc_reg, rsp_pc_next;
  logic [CW-1:0] out_reg, out_next;
  logic [CW-1:0] drop_reg, drop_next;
  logic [CW-1:0] count_reg, count_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [31:0]   head_instr_reg, head_instr_next;
  logic [31:0]   head_pc_reg, head_pc_next;

  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];

  logic [31:0]   redir_target;
  logic          redir_misaligned;
  logic [CW:0]   credit_used;
  logic          accept, rsp_ok, rsp_drop, push, pop;

`ifdef CAYDE_FETCH_MISALIGN_CHECK_EN
  assign redir_target     = redirect_pc;
  assign redir_misaligned = |redirect_pc[1:0];
  assign fetch_err        = (state_reg == ST_HALT);
`else
  assign redir_target     = redirect_pc & 32'hFFFF_FFFC;
  assign redir_misaligned = 1'b0;
  assign fetch_err        = 1'b0;
`endif

  // Buffered words plus in-flight requests may never exceed the buffer size.
  assign credit_used    = {1'b0, count_reg} + {1'b0, out_reg};
  assign imem_req_valid = rst_n & (state_reg == ST_RUN) & ~redirect_valid & (credit_used < DEPTH_C);
  assign imem_req_addr  = pc_reg;
  assign accept         = imem_req_valid & imem_req_ready;

  assign rsp_ok   = imem_rsp_valid & (out_reg != '0);
  assign rsp_drop = rsp_ok & (drop_reg != '0);
  assign push     = rsp_ok & ~rsp_drop & ~redirect_valid;

  assign instr_valid = rst_n & (count_reg != '0) & ~redirect_valid;
  assign pop         = instr_valid & instr_ready;
  assign instr_out   = head_instr_reg;
  assign instr_pc    = head_pc_reg;

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    rsp_pc_next = rsp_pc_reg;
    out_next    = out_reg + CW'(accept) - CW'(rsp_ok);
    drop_next   = drop_reg;
    if (redirect_valid) begin
      state_next  = redir_misaligned ? ST_HALT : ST_RUN;
      pc_next     = redir_target;
      rsp_pc_next = redir_target;
      // Everything still in flight belongs to the old stream.
      drop_next   = out_reg - CW'(rsp_ok);
    end else begin
      if (accept)
        pc_next = pc_reg + 32'd4;
      if (push)
        rsp_pc_next = rsp_pc_reg + 32'd4;
      if (rsp_drop)
        drop_next = drop_reg - CW'(1);
    end
  end

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    if (redirect_valid) begin
      count_next  = '0;
      rd_ptr_next = wr_ptr_reg;
    end else begin
      if (push)
        wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_next = rd_ptr_reg + AW'(1);
      count_next = count_reg + CW'(push) - CW'(pop);
    end
    // Head registers preload the entry that will be at the front next cycle.
    head_instr_next = head_instr_reg;
    head_pc_next    = head_pc_reg;
    if (count_next != '0) begin
      if (push && (rd_ptr_next == wr_ptr_reg)) begin
        head_instr_next = imem_rsp_data;
        head_pc_next    = rsp_pc_reg;
      end else begin
        head_instr_next = fifo_instr[rd_ptr_next];
        head_pc_next    = fifo_pc[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr_reg] <= imem_rsp_data;
      fifo_pc[wr_ptr_reg]    <= rsp_pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_RUN;
      pc_reg         <= RESET_PC;
      rsp_pc_reg     <= RESET_PC;
      out_reg        <= '0;
      drop_reg       <= '0;
      count_reg      <= '0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      head_instr_reg <= '0;
      head_pc_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      rsp_pc_reg     <= rsp_pc_next;
      out_reg        <= out_next;
      drop_reg       <= drop_next;
      count_reg      <= count_next;
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      head_instr_reg <= head_instr_next;
      head_pc_reg    <= head_pc_next;
    end
  end

endmodule

// File: tb/tb_cayde_fetch.sv
// Scoreboard bench for cayde_fetch: a memory model with random latency, a stream-level
// reference (after each redirect/reset the decoder must see target, target+4, ...).
module tb_cayde_fetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_out, instr_pc;
  logic        fetch_err;

  always #5 clk = ~clk;

  cayde_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc), .fetch_err(fetch_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat_min = 1, lat_max = 1, ready_pct = 100;
  int accept_cnt = 0, deliv_cnt = 0;
  logic [31:0] last_pc = '0;
  logic [31:0] exp_req_addr;
  logic halted = 1'b0;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend_q[$];
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_stream(input logic [31:0] start);
    exp_q.delete();
    for (int k = 0; k < 1024; k++) exp_q.push_back(start + 32'(4 * k));
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    logic [31:0] eff;
    eff = tgt;
`ifndef CAYDE_FETCH_MISALIGN_CHECK_EN
    eff[1:0] = 2'b00;
`endif
    halted = (eff[1:0] != 2'b00);
    exp_req_addr = eff;
    exp_q.delete();
    if (!halted) expect_stream(eff);
    redirect_pc = tgt;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    halted = 1'b0;
    exp_req_addr = RST_PC;
    expect_stream(RST_PC);
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic expect_first(input string name, input logic [31:0] pc);
    int c0;
    bit got;
    c0 = deliv_cnt;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (deliv_cnt != c0) got = 1'b1;
    end
    chk(name, got ? last_pc : 32'hDEAD_BEEF, pc);
  endtask

  // Instruction memory: in-order, random latency >= 1, one response per cycle.
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_q.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        accept_cnt++;
        checks++;
        if (halted || imem_req_addr !== exp_req_addr) begin
          errors++;
          $display("FAIL req_addr actual=%h expected=%h halted=%0d", imem_req_addr, exp_req_addr, halted);
        end
        exp_req_addr = exp_req_addr + 32'd4;
        pend_q.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
        checks++;
        if (pend_q.size() > DEPTH) begin
          errors++;
          $display("FAIL outstanding actual=%0d limit=%0d", pend_q.size(), DEPTH);
        end
      end
      @(posedge clk);
      #1;
      imem_req_ready = ($urandom_range(99) < ready_pct);
      imem_rsp_valid = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
    end
  end

  // Monitor: every handshake to the decoder must match the next expected stream entry.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && redirect_valid) begin
        checks++;
        if (instr_valid || imem_req_valid) begin
          errors++;
          $display("FAIL redirect_gate actual instr_valid=%0d req_valid=%0d expected 0 0", instr_valid, imem_req_valid);
        end
      end
      if (rst_n && instr_valid && instr_ready) begin
        deliv_cnt++;
        last_pc = instr_pc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_delivery actual pc=%h data=%h expected none", instr_pc, instr_out);
        end else begin
          e = exp_q.pop_front();
          if (instr_pc !== e || instr_out !== mem_word(e)) begin
            errors++;
            $display("FAIL delivery actual pc=%h data=%h expected pc=%h data=%h", instr_pc, instr_out, e, mem_word(e));
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] t;
    int a0, since;
    bit found;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    exp_req_addr = RST_PC;
    expect_stream(RST_PC);
    repeat (2) tick();
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_out", instr_out, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_fetch_err", fetch_err, 0);

    // Reset release, 1-cycle memory, decoder always ready.
    tick();
    rst_n = 1'b1;
    instr_ready = 1'b1;
    #1;
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, RST_PC);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imem_rsp_valid) found = 1'b1;
    end
    chk("first_rsp_seen", 32'(found), 1);
    @(negedge clk);
    chk("valid_after_first_rsp", instr_valid, 1);
    chk("first_instr_pc", instr_pc, RST_PC);
    repeat (20) tick();

    // Decoder stalled: only FIFO_DEPTH requests may be accepted.
    instr_ready = 1'b0;
    do_redirect(32'h0);
    a0 = accept_cnt;
    repeat (10) tick();
    chk("accepts_while_stalled", 32'(accept_cnt - a0), DEPTH);
    chk("req_valid_stalled", imem_req_valid, 0);
    instr_ready = 1'b1;
    repeat (10) tick();

    // Redirect with a full buffer and requests in flight.
    lat_min = 3; lat_max = 3;
    instr_ready = 1'b0;
    repeat (8) tick();
    instr_ready = 1'b1;
    do_redirect(32'h100);
    expect_first("redirect_first_pc", 32'h100);
    repeat (10) tick();

    // Redirect coinciding with a response, then back-to-back redirects while dropping.
    lat_min = 1; lat_max = 1;
    repeat (5) tick();
    do_redirect(32'h300);
    expect_first("redirect_with_rsp_pc", 32'h300);
    lat_min = 3; lat_max = 3;
    repeat (5) tick();
    do_redirect(32'h180);
    do_redirect(32'h200);
    expect_first("double_redirect_pc", 32'h200);
    lat_min = 1; lat_max = 2;
    repeat (10) tick();

`ifdef CAYDE_FETCH_MISALIGN_CHECK_EN
    do_redirect(32'h102);
    chk("fetch_err_set", fetch_err, 1);
    for (int i = 0; i < 10; i++) begin
      chk("halt_no_req", imem_req_valid, 0);
      tick();
    end
    do_redirect(32'h104);
    chk("fetch_err_clear", fetch_err, 0);
    expect_first("restart_after_halt_pc", 32'h104);
`else
    do_redirect(32'h102);
    chk("fetch_err_tied", fetch_err, 0);
    expect_first("misaligned_forced_pc", 32'h100);
`endif
    repeat (10) tick();

    // Reset mid-stream.
    do_reset();
    chk("mid_rst_instr_valid", instr_valid, 0);
    chk("mid_rst_instr_out", instr_out, 0);
    chk("mid_rst_instr_pc", instr_pc, 0);
    chk("mid_rst_fetch_err", fetch_err, 0);
    chk("mid_rst_req_addr", imem_req_addr, RST_PC);
    chk("mid_rst_req_valid", imem_req_valid, 1);
    expect_first("post_reset_pc", RST_PC);

    // Randomized traffic.
    lat_min = 1; lat_max = 4; ready_pct = 70;
    since = 0;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(99) < 75);
      if ($urandom_range(499) == 0) begin
        do_reset();
        since = 0;
      end else if ($urandom_range(24) == 0 || since > 400) begin
        t = $urandom();
        t[1:0] = 2'b00;
        do_redirect(t);
        since = 0;
      end else begin
        tick();
        since++;
      end
    end
    instr_ready = 1'b1;
    ready_pct = 100;
    repeat (20) tick();
    chk("deliveries_made", 32'(deliv_cnt > 500), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
